// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_ctrl_pkg
//  Description : Command codes, FSM state encoding and the window address
//                helper shared by the LCD window controller files.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_REFRESH  = 4'd0;
  localparam logic [3:0] CMD_LOAD     = 4'd1;
  localparam logic [3:0] CMD_ZOOM_IN  = 4'd2;
  localparam logic [3:0] CMD_ZOOM_OUT = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_LEFT     = 4'd5;
  localparam logic [3:0] CMD_UP       = 4'd6;
  localparam logic [3:0] CMD_DOWN     = 4'd7;
  localparam logic [3:0] CMD_MIRROR_X = 4'd8;
  localparam logic [3:0] CMD_MIRROR_Y = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Pixel-memory address {row, col} of window position (r, c).
  // Mirrors are applied to the window coordinates before any scaling/offset.
  function automatic int win_addr(
    input int   img_log2,
    input int   win_log2,
    input int   ox,
    input int   oy,
    input int   r,
    input int   c,
    input logic zoom_in,
    input logic mirror_x,
    input logic mirror_y
  );
    int win;
    int rr;
    int cc;
    int row;
    int col;
    win = 1 << win_log2;
    rr  = mirror_y ? (win - 1 - r) : r;
    cc  = mirror_x ? (win - 1 - c) : c;
    if (zoom_in) begin
      row = oy + rr;
      col = ox + cc;
    end else begin
      row = rr << (img_log2 - win_log2);
      col = cc << (img_log2 - win_log2);
    end
    return (row << img_log2) | col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_pix_mem.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pix_mem
//  Description : Image register file, one synchronous write port and one
//                combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_pix_mem #(
  parameter int DW = 8,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // Write one pixel per enabled cycle
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/lcd_win_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_win_ctrl
//  Description : LCD image-window controller. Loads an IMG x IMG raster and
//                streams a WIN x WIN view (zoom-out subsampled or zoom-in
//                1:1 with movable origin), with optional mirroring.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_win_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int DW       = 8,
  parameter int IMG_LOG2 = 3,
  parameter int WIN_LOG2 = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] datain,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int c_IMG = 1 << IMG_LOG2;
  localparam int c_WIN = 1 << WIN_LOG2;
  localparam int c_AW  = 2 * IMG_LOG2;
  localparam int c_OW  = 2 * WIN_LOG2;
  localparam logic [IMG_LOG2-1:0] c_MAX_ORG = IMG_LOG2'(c_IMG - c_WIN);
  localparam logic [IMG_LOG2-1:0] c_CENTER  = IMG_LOG2'((c_IMG - c_WIN) / 2);
  localparam logic [c_AW-1:0]     c_LOAD_LAST = c_AW'(c_IMG * c_IMG - 1);
  localparam logic [c_AW-1:0]     c_OUT_LAST  = c_AW'(c_WIN * c_WIN - 1);

  state_t               r_state;
  state_t               w_next;
  logic [c_AW-1:0]      r_cnt;
  logic [3:0]           r_cmd;
  logic                 r_zoom_in;
  logic [IMG_LOG2-1:0]  r_ox;
  logic [IMG_LOG2-1:0]  r_oy;
  logic                 r_mx;
  logic                 r_my;
  logic [DW-1:0]        r_dout;
  logic                 r_valid;
  logic                 r_busy;

  logic                 w_accept;
  logic                 w_load_last;
  logic                 w_out_last;
  logic [c_OW-1:0]      w_k;
  logic [WIN_LOG2-1:0]  w_r;
  logic [WIN_LOG2-1:0]  w_c;
  logic [c_AW-1:0]      w_raddr;
  logic [DW-1:0]        w_rdata;

  assign w_accept    = (r_state == ST_IDLE) && cmd_valid && !r_busy;
  assign w_load_last = (r_state == ST_LOAD) && (r_cnt == c_LOAD_LAST);
  assign w_out_last  = (r_state == ST_OUT)  && (r_cnt == c_OUT_LAST);

  // Window position of the pixel being streamed: k -> (row, col)
  assign w_k     = r_cnt[c_OW-1:0];
  assign w_r     = w_k[c_OW-1:WIN_LOG2];
  assign w_c     = w_k[WIN_LOG2-1:0];
  assign w_raddr = c_AW'(win_addr(IMG_LOG2, WIN_LOG2, int'(r_ox), int'(r_oy),
                                  int'(w_r), int'(w_c), r_zoom_in, r_mx, r_my));

  lcd_pix_mem #(
    .DW (DW),
    .AW (c_AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (r_state == ST_LOAD),
    .i_waddr (r_cnt),
    .i_wdata (datain),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (cmd == CMD_LOAD) ? ST_LOAD : ST_EXEC;
      ST_LOAD: if (w_load_last) w_next = ST_OUT;
      ST_EXEC: w_next = ST_OUT;
      ST_OUT:  if (w_out_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Shared load-sample / output-pixel counter, restarts at each phase end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_LOAD || r_state == ST_OUT) begin
      r_cnt <= (w_load_last || w_out_last) ? '0 : r_cnt + c_AW'(1);
    end
  end

  // View configuration: LOAD resets it on acceptance, other commands apply in EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd     <= CMD_REFRESH;
      r_zoom_in <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_mx      <= 1'b0;
      r_my      <= 1'b0;
    end else if (w_accept) begin
      r_cmd <= cmd;
      if (cmd == CMD_LOAD) begin
        r_zoom_in <= 1'b0;
        r_ox      <= '0;
        r_oy      <= '0;
        r_mx      <= 1'b0;
        r_my      <= 1'b0;
      end
    end else if (r_state == ST_EXEC) begin
      case (r_cmd)
        CMD_ZOOM_IN: begin
          r_zoom_in <= 1'b1;
          r_ox      <= c_CENTER;
          r_oy      <= c_CENTER;
        end
        CMD_ZOOM_OUT: begin
          r_zoom_in <= 1'b0;
          r_ox      <= '0;
          r_oy      <= '0;
        end
        CMD_RIGHT: if (r_zoom_in && r_ox != c_MAX_ORG) r_ox <= r_ox + IMG_LOG2'(1);
        CMD_LEFT:  if (r_zoom_in && r_ox != '0)        r_ox <= r_ox - IMG_LOG2'(1);
        CMD_UP:    if (r_zoom_in && r_oy != '0)        r_oy <= r_oy - IMG_LOG2'(1);
        CMD_DOWN:  if (r_zoom_in && r_oy != c_MAX_ORG) r_oy <= r_oy + IMG_LOG2'(1);
        CMD_MIRROR_X: r_mx <= ~r_mx;
        CMD_MIRROR_Y: r_my <= ~r_my;
        default: ;
      endcase
    end
  end

  // Registered output pixel, qualifier and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_OUT);
      if (r_state == ST_OUT) r_dout <= w_rdata;
      if (w_accept)        r_busy <= 1'b1;
      else if (w_out_last) r_busy <= 1'b0;
    end
  end

  assign dataout      = r_dout;
  assign output_valid = r_valid;
  assign busy         = r_busy;

endmodule
`default_nettype wire
